slave_comm_tx: RTL and testbench



---
 rtl/slave_comm_tx.sv | 216 +++++++++++++++++++++
 tb/tb_slave_comm_tx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_comm_tx.sv
// Message-link serial transmitter: buffers one byte frame, appends CRC-8 and shifts it out MSB-first.
// Optional build macro COMM_TX_CRC_ERR_INJ_EN adds crc_err_inj_i to invert the transmitted CRC byte.
module slave_comm_tx #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_CLKS   = 4
) (
  input  logic       clk_sys_i,
  input  logic       rst_i,
  input  logic       tx_data_vld_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_data_last_i,
`ifdef COMM_TX_CRC_ERR_INJ_EN
  input  logic       crc_err_inj_i,
`endif
  output logic       tx_ready_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o,
  output logic       msg_clk_o,
  output logic       msg_fsx_o,
  output logic       msg_tx_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(2 ** ADDR_WIDTH - 2);

  typedef enum logic [2:0] {StIdle, StLoad, StArm, StShift, StCrc, StGap} state_e;

  state_e                state_q, state_d;
  logic [DivW-1:0]       div_q, div_d;
  logic                  msg_clk_q, msg_clk_d;
  logic                  fsx_q, fsx_d;
  logic [7:0]            shreg_q, shreg_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] byte_idx_q, byte_idx_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            crc_q, crc_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic                  arm_q, arm_d;
  logic                  inj_q, inj_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [7:0]            mem [2**ADDR_WIDTH];
  logic [7:0]            rd_data_q;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  div_wrap, fall, accept, at_max, is_last, inj_in;
  logic [7:0]            crc_out;

`ifdef COMM_TX_CRC_ERR_INJ_EN
  assign inj_in = crc_err_inj_i;
`else
  assign inj_in = 1'b0;
`endif

  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign div_wrap   = (div_q == DivW'(CLK_DIV - 1));
  assign fall       = div_wrap & msg_clk_q;
  assign tx_ready_o = (state_q == StIdle) || (state_q == StLoad);
  assign accept     = tx_data_vld_i & tx_ready_o;
  assign wr_addr    = (state_q == StIdle) ? '0 : count_q;
  // The byte landing at the last usable address closes the frame even without last.
  assign at_max     = (wr_addr == LastAddr);
  assign is_last    = tx_data_last_i | at_max;
  assign crc_out    = inj_q ? ~crc_q : crc_q;

  // Frame buffer; the read port prefetches the byte the shifter will need next.
  always_ff @(posedge clk_sys_i) begin
    if (accept) mem[wr_addr] <= tx_data_i;
    rd_data_q <= mem[byte_idx_q];
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_wrap ? '0 : div_q + 1'b1;
    msg_clk_d  = div_wrap ? ~msg_clk_q : msg_clk_q;
    fsx_d      = fsx_q;
    shreg_d    = shreg_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    bit_cnt_d  = bit_cnt_q;
    crc_d      = crc_q;
    gap_d      = gap_q;
    arm_d      = arm_q;
    inj_d      = inj_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle, StLoad: begin
        if (accept) begin
          count_d = (state_q == StIdle) ? ADDR_WIDTH'(1) : count_q + 1'b1;
          busy_d  = 1'b1;
          err_d   = ~tx_data_last_i & at_max;
          state_d = StLoad;
          if (is_last) begin
            inj_d   = inj_in;
            arm_d   = 1'b0;
            state_d = StArm;
          end
        end
      end
      StArm: begin
        // arm_q is low only in the first ARM cycle, guaranteeing two cycles after the last write.
        arm_d = 1'b1;
        if (arm_q && fall) begin
          shreg_d    = rd_data_q;
          fsx_d      = 1'b1;
          bit_cnt_d  = 4'd1;
          crc_d      = crc8_upd(8'hFF, rd_data_q);
          byte_idx_d = byte_idx_q + 1'b1;
          state_d    = StShift;
        end
      end
      StShift: begin
        if (fall) begin
          if (bit_cnt_q != 4'd8) begin
            shreg_d   = {shreg_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (byte_idx_q == count_q) begin
            shreg_d   = crc_out;
            bit_cnt_d = 4'd1;
            state_d   = StCrc;
          end else begin
            shreg_d    = rd_data_q;
            bit_cnt_d  = 4'd1;
            crc_d      = crc8_upd(crc_q, rd_data_q);
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      StCrc: begin
        if (fall) begin
          if (bit_cnt_q != 4'd8) begin
            shreg_d   = {shreg_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            shreg_d = 8'h00;
            fsx_d   = 1'b0;
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (fall) begin
          if (gap_q == GapW'(GAP_CLKS - 1)) begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            byte_idx_d = '0;
            state_d    = StIdle;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      div_q      <= '0;
      msg_clk_q  <= 1'b0;
      fsx_q      <= 1'b0;
      shreg_q    <= 8'h00;
      count_q    <= '0;
      byte_idx_q <= '0;
      bit_cnt_q  <= 4'd0;
      crc_q      <= 8'hFF;
      gap_q      <= '0;
      arm_q      <= 1'b0;
      inj_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      msg_clk_q  <= msg_clk_d;
      fsx_q      <= fsx_d;
      shreg_q    <= shreg_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      crc_q      <= crc_d;
      gap_q      <= gap_d;
      arm_q      <= arm_d;
      inj_q      <= inj_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;
  assign tx_err_o  = err_q;
  assign msg_clk_o = msg_clk_q;
  assign msg_fsx_o = fsx_q;
  assign msg_tx_o  = shreg_q[7];

endmodule

// File: tb/tb_slave_comm_tx.sv
// Scoreboard bench for slave_comm_tx: a driver queues expected frames, a serial monitor checks them.
module tb_slave_comm_tx;
  localparam int unsigned AW       = 9;
  localparam int unsigned CD       = 2;
  localparam int unsigned GAP      = 4;
  localparam int          MaxBytes = 2 ** AW - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [7:0] data = 8'h00;
  logic       last = 1'b0;
  logic       inj = 1'b0;
  logic       ready, busy, done, err, msg_clk, fsx, txd;

  slave_comm_tx #(.ADDR_WIDTH(AW), .CLK_DIV(CD), .GAP_CLKS(GAP)) dut (
    .clk_sys_i     (clk),
    .rst_i         (rst),
    .tx_data_vld_i (vld),
    .tx_data_i     (data),
    .tx_data_last_i(last),
`ifdef COMM_TX_CRC_ERR_INJ_EN
    .crc_err_inj_i (inj),
`endif
    .tx_ready_o    (ready),
    .tx_busy_o     (busy),
    .tx_done_o     (done),
    .tx_err_o      (err),
    .msg_clk_o     (msg_clk),
    .msg_fsx_o     (fsx),
    .msg_tx_o      (txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_len[$];
  logic [7:0] exp_data[$];
  bit rx_bits[$];
  bit in_gap = 0;
  bit abort_flag = 0;
  int gap_rises = 0;
  int frames_done = 0;
  int dones_seen = 0;
  logic prev_clk = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, expv);
    end
  endtask

  // Reference CRC: serial LFSR, one message bit at a time.
  function automatic logic [7:0] ref_crc(input logic [7:0] d[$]);
    logic [7:0] crc = 8'hFF;
    logic fb;
    foreach (d[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb  = crc[7] ^ d[i][b];
        crc = {crc[6:0], 1'b0};
        if (fb) crc = crc ^ 8'h07;
      end
    end
    return crc;
  endfunction

  task automatic send_frame(input logic [7:0] d[$], input bit use_last, input bit do_inj,
                            input int crc_fixed);
    int n = d.size();
    logic [7:0] c;
    c = (crc_fixed >= 0) ? 8'(crc_fixed) : ref_crc(d);
    if (do_inj) c = ~c;
    exp_len.push_back(n);
    foreach (d[i]) exp_data.push_back(d[i]);
    exp_data.push_back(c);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!ready && t < 20000) begin
        @(negedge clk);
        t++;
      end
      if (!ready) begin
        check("ready_timeout", 0, 1);
        return;
      end
      vld  = 1'b1;
      data = d[i];
      last = use_last && (i == n - 1);
      inj  = do_inj;
      @(negedge clk);
      vld  = 1'b0;
      last = 1'b0;
      check("err_pulse", err, (i == MaxBytes - 1) && !(use_last && i == n - 1));
      if (i == 0) check("busy_set", busy, 1);
    end
    check("ready_drop", ready, 0);
  endtask

  // Random vld while ready is low must be ignored; returns once the frame is done.
  task automatic wait_idle_with_junk();
    int t = 0;
    while (t < 40000) begin
      @(negedge clk);
      if (ready) break;
      vld  = 1'($urandom);
      data = 8'($urandom);
      last = 1'($urandom);
      t++;
    end
    vld  = 1'b0;
    last = 1'b0;
    check("frame_complete", ready, 1);
  endtask

  task automatic compare_frame();
    int n;
    logic [7:0] e, g;
    if (exp_len.size() == 0) begin
      check("unexpected_frame", 1, 0);
      return;
    end
    n = exp_len.pop_front();
    check("fsx_width", rx_bits.size(), (n + 1) * 8);
    for (int k = 0; k <= n; k++) begin
      e = exp_data.pop_front();
      if (rx_bits.size() == (n + 1) * 8) begin
        for (int b = 0; b < 8; b++) g[7-b] = rx_bits[k*8+b];
        check($sformatf("frame_byte[%0d]", k), g, e);
      end
    end
    frames_done++;
  endtask

  always @(negedge clk) begin
    if (abort_flag) begin
      rx_bits.delete();
      in_gap     = 0;
      abort_flag = 0;
    end else begin
      if (msg_clk && !prev_clk) begin
        if (fsx) begin
          rx_bits.push_back(txd);
        end else begin
          if (rx_bits.size() > 0) begin
            compare_frame();
            rx_bits.delete();
            in_gap    = 1;
            gap_rises = 0;
          end
          if (in_gap) gap_rises++;
        end
      end
      if (done) begin
        check("done_after_frame", in_gap, 1);
        check("done_gap_clks", gap_rises, GAP);
        check("busy_clear", busy, 0);
        in_gap = 0;
        dones_seen++;
      end
    end
    prev_clk = msg_clk;
  end

  initial begin
    logic [7:0] d[$];
    int t;
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_msg_clk", msg_clk, 0);
    check("rst_fsx", fsx, 0);
    check("rst_tx", txd, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    d = {8'h00};
    send_frame(d, 1, 0, 8'hF3);
    wait_idle_with_junk();
    d = {8'hFF};
    send_frame(d, 1, 0, 8'h00);
    wait_idle_with_junk();

    repeat (6) begin
      d.delete();
      repeat ($urandom_range(1, 12)) d.push_back(8'($urandom));
      send_frame(d, 1, 0, -1);
      wait_idle_with_junk();
    end

    d.delete();
    for (int i = 0; i < 256; i++) d.push_back(8'(i));
    send_frame(d, 1, 0, -1);
    wait_idle_with_junk();

    // Overflow: no last ever asserted, the final buffer slot closes the frame.
    d.delete();
    repeat (MaxBytes) d.push_back(8'($urandom));
    send_frame(d, 0, 0, -1);
    wait_idle_with_junk();

    // Reset during the third byte of a frame.
    d.delete();
    repeat (8) d.push_back(8'($urandom));
    send_frame(d, 1, 0, -1);
    t = 0;
    while (rx_bits.size() < 20 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("reach_byte3", rx_bits.size() >= 20, 1);
    #2;
    abort_flag = 1;
    exp_len.delete();
    exp_data.delete();
    rst = 1'b1;
    #1;
    check("async_rst_fsx", fsx, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", ready, 1);
    check("async_rst_msg_clk", msg_clk, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);

    d.delete();
    repeat (5) d.push_back(8'($urandom));
    send_frame(d, 1, 0, -1);
    wait_idle_with_junk();

`ifdef COMM_TX_CRC_ERR_INJ_EN
    d = {8'h00};
    send_frame(d, 1, 1, 8'hF3);
    wait_idle_with_junk();
    inj = 1'b0;
`endif

    repeat (20) @(negedge clk);
    check("queue_drained", exp_len.size(), 0);
    check("done_count", dones_seen, frames_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
